// File: rtl/plab4_net_router_output_terminal_ctrl_tp.sv
// Terminal-side output controller for a two-domain timing-protected ring router.
// Optional same-cycle bypass of an empty queue: define PLAB4_NET_OTC_BYPASS_EN.
module plab4_net_router_output_terminal_ctrl_tp #(
    parameter int p_router_id      = 0,
    parameter int p_num_routers    = 8,
    parameter int p_msg_nbits      = 32,
    parameter int p_queue_depth    = 2,
    parameter int p_num_free_nbits = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        domain,
    input  logic [2:0]                  reqs,
    output logic [2:0]                  grants,
    input  logic [p_msg_nbits-1:0]      in_msg,
    output logic                        out_val_d0,
    input  logic                        out_rdy_d0,
    output logic [p_msg_nbits-1:0]      out_msg_d0,
    output logic                        out_val_d1,
    input  logic                        out_rdy_d1,
    output logic [p_msg_nbits-1:0]      out_msg_d1,
    output logic [p_num_free_nbits-1:0] num_free_d0,
    output logic [p_num_free_nbits-1:0] num_free_d1
);

    localparam int c_ptr_nbits = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;

    typedef logic [c_ptr_nbits-1:0]      ptr_t;
    typedef logic [p_num_free_nbits-1:0] cnt_t;

    localparam cnt_t c_depth = cnt_t'(p_queue_depth);

    // Router identity is carried only for hierarchy consistency.
    logic [31:0] unused_params;
    assign unused_params = 32'(p_router_id) ^ 32'(p_num_routers);

    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [2:0] prio);
        logic [2:0] g;
        int         base;
        int         idx;
        g    = '0;
        base = 0;
        for (int i = 0; i < 3; i++)
            if (prio[i]) base = i;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = 2; k >= 0; k--) begin
            idx = (base + k) % 3;
            if (req[idx]) g = 3'b001 << idx;
        end
        return g;
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(p_queue_depth - 1)) return '0;
        return p + ptr_t'(1);
    endfunction

    logic [2:0]             prio  [2];
    cnt_t                   count [2];
    ptr_t                   head  [2];
    ptr_t                   tail  [2];
    logic [p_msg_nbits-1:0] mem   [2][p_queue_depth];

    logic [1:0] rdy;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] byp;
    logic [1:0] val;
    logic [2:0] prio_act;
    logic       space_act;
    logic       grant_any;

    assign rdy = {out_rdy_d1, out_rdy_d0};

    // Grant enable looks only at the registered count of the active domain.
    always_comb begin
        prio_act  = domain ? prio[1] : prio[0];
        space_act = (domain ? count[1] : count[0]) < c_depth;
        grants    = '0;
        if (reset && space_act) grants = rr_pick(reqs, prio_act);
    end

    assign grant_any = |grants;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
`ifdef PLAB4_NET_OTC_BYPASS_EN
            byp[d]  = grant_any && (domain == 1'(d)) && (count[d] == '0) && rdy[d];
`else
            byp[d]  = 1'b0;
`endif
            push[d] = grant_any && (domain == 1'(d)) && !byp[d];
            pop[d]  = (count[d] != '0) && rdy[d];
            val[d]  = (count[d] != '0) || byp[d];
        end
    end

    assign out_val_d0  = val[0];
    assign out_val_d1  = val[1];
    assign out_msg_d0  = byp[0] ? in_msg : mem[0][head[0]];
    assign out_msg_d1  = byp[1] ? in_msg : mem[1][head[1]];
    assign num_free_d0 = c_depth - count[0];
    assign num_free_d1 = c_depth - count[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                count[d] <= '0;
                head[d]  <= '0;
                tail[d]  <= '0;
                prio[d]  <= 3'b001;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (push[d]) tail[d] <= ptr_inc(tail[d]);
                if (pop[d])  head[d] <= ptr_inc(head[d]);
                if (push[d] && !pop[d])
                    count[d] <= count[d] + cnt_t'(1);
                else if (pop[d] && !push[d])
                    count[d] <= count[d] - cnt_t'(1);
            end
            // Only the active domain's pointer rotates; the other holds.
            if (grant_any) begin
                if (domain) prio[1] <= {grants[1:0], grants[2]};
                else        prio[0] <= {grants[1:0], grants[2]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (push[d]) mem[d][tail[d]] <= in_msg;
    end

endmodule

// File: tb/tb_plab4_net_router_output_terminal_ctrl_tp.sv
// Randomized scoreboard bench for the two-domain terminal output controller.
module tb_plab4_net_router_output_terminal_ctrl_tp;

    localparam int DEPTH = 2;
    localparam int MW    = 32;
    localparam int FW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          domain;
    logic [2:0]    reqs;
    logic [2:0]    grants;
    logic [MW-1:0] in_msg;
    logic          out_val_d0, out_rdy_d0, out_val_d1, out_rdy_d1;
    logic [MW-1:0] out_msg_d0, out_msg_d1;
    logic [FW-1:0] num_free_d0, num_free_d1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [MW-1:0] exp_q [2][$];
    int  rr_ptr [2];
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    plab4_net_router_output_terminal_ctrl_tp #(
        .p_router_id(0), .p_num_routers(8), .p_msg_nbits(MW),
        .p_queue_depth(DEPTH), .p_num_free_nbits(FW)
    ) dut (
        .clk(clk), .reset(reset), .domain(domain), .reqs(reqs), .grants(grants),
        .in_msg(in_msg),
        .out_val_d0(out_val_d0), .out_rdy_d0(out_rdy_d0), .out_msg_d0(out_msg_d0),
        .out_val_d1(out_val_d1), .out_rdy_d1(out_rdy_d1), .out_msg_d1(out_msg_d1),
        .num_free_d0(num_free_d0), .num_free_d1(num_free_d1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference arbiter: first requester at or after the domain's pointer, if the queue has room.
    function automatic logic [2:0] model_grant(input logic dom, input logic [2:0] r);
        int p;
        if (exp_q[dom].size() >= DEPTH) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            p = (rr_ptr[dom] + k) % 3;
            if (r[p]) return 3'b001 << p;
        end
        return 3'b000;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            rr_ptr[d] = 0;
        end
    endtask

    task automatic drive_cycle(input logic dom, input logic [2:0] r, input logic r0, input logic r1);
        logic [2:0]    exp_g;
        logic [MW-1:0] m;
        @(negedge clk);
        m          = $urandom;
        domain     = dom;
        reqs       = r;
        in_msg     = m;
        out_rdy_d0 = r0;
        out_rdy_d1 = r1;
        #1;
        exp_g = model_grant(dom, r);
        check("grants", 32'(grants), 32'(exp_g));
        #2;
        if (exp_g != 3'b000) begin
            for (int i = 0; i < 3; i++)
                if (exp_g[i]) rr_ptr[dom] = (i + 1) % 3;
            exp_q[dom].push_back(m);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grants"}, 32'(grants), 32'(0));
        check({tag, "_val_d0"}, 32'(out_val_d0), 32'(0));
        check({tag, "_val_d1"}, 32'(out_val_d1), 32'(0));
        check({tag, "_free_d0"}, 32'(num_free_d0), 32'(DEPTH));
        check({tag, "_free_d1"}, 32'(num_free_d1), 32'(DEPTH));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #4;
        mon_en = 1'b0;
        domain = 1'b0;
        reqs   = 3'b111;
        reset  = 1'b0;
        #1;
        model_clear();
        check_idle("rst_asserted");
        @(negedge clk);
        reset = 1'b1;
        reqs  = 3'b000;
        #1;
        check_idle("rst_released");
        mon_en = 1'b1;
    endtask

    task automatic mon_dom(input int d, input logic v, input logic rdy,
                           input logic [MW-1:0] msg, input logic [FW-1:0] nf);
        int sz;
        sz = exp_q[d].size();
        check($sformatf("out_val_d%0d", d), 32'(v), 32'(sz != 0));
        check($sformatf("num_free_d%0d", d), 32'(nf), 32'(DEPTH - sz));
        if (sz != 0) begin
            if (v) check($sformatf("out_msg_d%0d", d), msg, exp_q[d][0]);
            if (rdy) void'(exp_q[d].pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                mon_dom(0, out_val_d0, out_rdy_d0, out_msg_d0, num_free_d0);
                mon_dom(1, out_val_d1, out_rdy_d1, out_msg_d1, num_free_d1);
            end
        end
    end

    initial begin
        reset = 1'b0; domain = 1'b0; reqs = 3'b111; in_msg = '0;
        out_rdy_d0 = 1'b0; out_rdy_d1 = 1'b0;
        model_clear();
        #1;
        check_idle("init_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        reqs  = 3'b000;
        #1;
        check_idle("init_released");
        mon_en = 1'b1;

        // Round robin across all three requesters on D1.
        repeat (3) drive_cycle(1'b0, 3'b111, 1'b1, 1'b1);
        drive_cycle(1'b0, 3'b000, 1'b1, 1'b1);

        // Fill D1 with the output stalled, then release it.
        repeat (4) drive_cycle(1'b0, 3'b001, 1'b0, 1'b1);
        repeat (4) drive_cycle(1'b0, 3'b001, 1'b1, 1'b1);
        repeat (3) drive_cycle(1'b0, 3'b000, 1'b1, 1'b1);

        // Full D2 queue must not disturb D1 grants.
        repeat (3) drive_cycle(1'b1, 3'b101, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b0, 3'b010, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b0, 3'b000, 1'b1, 1'b1);

        // Pointers persist across domain switches.
        do_reset();
        drive_cycle(1'b0, 3'b001, 1'b1, 1'b1);
        drive_cycle(1'b1, 3'b100, 1'b1, 1'b1);
        drive_cycle(1'b0, 3'b111, 1'b1, 1'b1);
        drive_cycle(1'b1, 3'b111, 1'b1, 1'b1);

        repeat (400)
            drive_cycle(1'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));

        // Reset while both queues hold data.
        repeat (4) drive_cycle(1'($urandom), 3'b111, 1'b0, 1'b0);
        do_reset();

        repeat (300)
            drive_cycle(1'($urandom), 3'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
        repeat (8) drive_cycle(1'($urandom), 3'b000, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_output_terminal_ctrl_tp.md
Name: plab4_net_router_output_terminal_ctrl_tp

Overview:
- Terminal-side output controller for a two-domain, timing-protected ring router (domains D1 and D2).
- Receives 3-bit switch requests from the west, terminal and east input controllers for the currently active domain.
- Issues round-robin grants and buffers granted messages in per-domain output queues.
- Delivers messages to per-domain terminal ports and exports per-domain free-slot counts to upstream.
- All arbitration state is replicated per domain, so one domain's traffic never alters the other domain's grant timing.

Parameters:
- p_router_id, 0, router index (informational; carried for hierarchy consistency)
- p_num_routers, 8, ring size
- p_msg_nbits, 32, message width
- p_queue_depth, 2, entries per domain output queue (legal range 1..4)
- p_num_free_nbits, 3, width of free-slot count; must hold p_queue_depth

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- domain  input  1  active domain select, label L (0 = D1, 1 = D2)
- reqs  input  3  requests, label Domain domain; bit0 = west, bit1 = terminal, bit2 = east
- grants  output  3  one-hot or zero grant, label Domain domain
- in_msg  input  p_msg_nbits  switched message, valid in any cycle where grants != 0, label Domain domain
- out_val_d0  output  1  D1 output valid
- out_rdy_d0  input  1  D1 output ready
- out_msg_d0  output  p_msg_nbits  D1 output message
- out_val_d1  output  1  D2 output valid
- out_rdy_d1  input  1  D2 output ready
- out_msg_d1  output  p_msg_nbits  D2 output message
- num_free_d0  output  p_num_free_nbits  D1 free slots, equal to p_queue_depth - count_d0
- num_free_d1  output  p_num_free_nbits  D2 free slots

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - count_d0 and count_d1 = 0; queue pointers = 0.
  - prio_d0 and prio_d1 = 3'b001.
  - out_val_d0/d1 = 0; num_free_d0/d1 = p_queue_depth.
  - grants forced to 0 while reset is low.
- Grant enable: space_act = (count of active domain < p_queue_depth), using the registered count only.
  - A same-cycle pop never enables a grant, so grant timing depends only on the active domain's own history.
- Grant selection (combinational): when space_act and reqs != 0, grant exactly one bit.
  - Select the first set bit at or after the active domain's prio pointer, wrapping 2 -> 0.
  - Otherwise grants = 0.
- Priority update (clock edge): if bit i is granted, the active domain's pointer becomes one-hot (i+1) mod 3. The inactive domain's pointer holds.
- Push (clock edge): when grants != 0, in_msg is written at the active domain's tail; tail and count advance.
- Pop, each domain independently every cycle:
  - out_val_dX = (count_dX != 0); out_msg_dX = head entry.
  - out_val_dX & out_rdy_dX advances the head and decrements count.
  - The inactive domain still drains.
- Simultaneous push and pop on the same domain: count unchanged, FIFO order preserved.
  - Full-plus-pop yields no push that cycle, because space uses the registered count.
- Pointers wrap modulo p_queue_depth.
- Latency: a message granted at edge N is visible on out_msg_dX after edge N (one cycle).
- Domain switch: no flush. Queues, counts and priority pointers of both domains persist; the next grant uses the new domain's pointer.
- out_msg_dX is don't-care when out_val_dX = 0. The bench must not check it.
- Reset asserted mid-transfer: all queued messages are discarded and state returns to reset values immediately.

Optional Feature:
- Macro: PLAB4_NET_OTC_BYPASS_EN.
- Defined:
  - When the active domain's queue is empty and that domain's out_rdy is high, a granted in_msg drives out_msg_dX with out_val_dX = 1 in the same cycle.
  - The message is not enqueued, and count and num_free are unchanged.
  - Grant logic is identical to the undefined case.
- Undefined: all messages pass through the queue with one-cycle latency.

Test Plan:
- Reset then idle: reset low mid-cycle -> grants = 0, out_val_d0/d1 = 0, num_free_d0/d1 = 2 immediately and after release.
- Round-robin D1: domain = 0, reqs = 3'b111 for 3 cycles, out_rdy_d0 = 1 -> grants 001, 010, 100; messages appear on out_msg_d0 one cycle later, in order.
- Full queue: domain = 0, out_rdy_d0 = 0, reqs = 3'b001 for 4 cycles -> grants on the first 2 cycles only, then num_free_d0 = 0. Raise out_rdy_d0 -> next grant comes one cycle after the first pop.
- Isolation: fill the D2 queue (count_d1 = 2), then domain = 0 with reqs = 3'b010 -> D1 grant timing and prio_d0 identical to a run with D2 empty.
- Pointer persistence: D1 grants west (prio_d0 -> 010), switch to domain 1 and grant east, switch back with reqs = 3'b111 -> grants = 3'b010.
- With PLAB4_NET_OTC_BYPASS_EN defined: empty D1 queue, out_rdy_d0 = 1, grant -> out_val_d0 = 1 in the grant cycle and num_free_d0 stays 2. Undefined: out_val_d0 = 1 one cycle later.
